// File: rtl/galetron_pkg.sv
// Shared Galetron definitions: opcode classes, immediate-extender selections,
// the fetch FSM state type and the split-field payload handed to the extender.
package galetron_pkg;

    localparam int unsigned INSTR_WIDTH = 32;
    localparam int unsigned IMM16_WIDTH = 16;
    localparam int unsigned IMM21_WIDTH = 21;
    localparam int unsigned EXT_WIDTH   = 2;

    // Opcode class lives in instr[31:30]
    localparam logic [1:0] OPC_RTYPE = 2'b00;
    localparam logic [1:0] OPC_ITYPE = 2'b01;
    localparam logic [1:0] OPC_JTYPE = 2'b10;
    localparam logic [1:0] OPC_STORE = 2'b11;

    localparam logic [EXT_WIDTH-1:0] EXT_IMM16A = 2'b00;
    localparam logic [EXT_WIDTH-1:0] EXT_IMM21  = 2'b01;
    localparam logic [EXT_WIDTH-1:0] EXT_IMM16C = 2'b10;
    localparam logic [EXT_WIDTH-1:0] EXT_NONE   = 2'b11;

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        DISCARD = 2'd1,
        VALID   = 2'd2
    } fetchState_t;

    typedef struct packed {
        logic [IMM16_WIDTH-1:0] immA;
        logic [IMM21_WIDTH-1:0] immB;
        logic [IMM16_WIDTH-1:0] immC;
        logic [EXT_WIDTH-1:0]   extSel;
    } instrFields_t;

    function automatic logic [EXT_WIDTH-1:0] extSelFor(input logic [1:0] opClass);
        logic [EXT_WIDTH-1:0] sel;
        sel = EXT_NONE;
        case (opClass)
            OPC_ITYPE: sel = EXT_IMM16A;
            OPC_JTYPE: sel = EXT_IMM21;
            OPC_STORE: sel = EXT_IMM16C;
            default:   sel = EXT_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/instruction_field_split.sv
// Combinational split of an instruction word into the immediate fields and
// extender selection; shared between fetch and decode.
module instruction_field_split
    import galetron_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0] instr,
    output instrFields_t           fields
);

    assign fields.immA   = instr[15:0];
    assign fields.immB   = instr[20:0];
    assign fields.immC   = {instr[25:21], instr[10:0]};
    assign fields.extSel = extSelFor(instr[31:30]);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Galetron fetch stage: owns the PC, runs the instruction-memory req/ack
// handshake and hands the latched instruction to decode over valid/ready.
module instruction_fetch_unit
    import galetron_pkg::*;
#(
    parameter int unsigned          PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
    parameter int unsigned          PC_STEP  = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    imem_req,
    output logic [PC_WIDTH-1:0]     imem_addr,
    input  logic                    imem_ack,
    input  logic [INSTR_WIDTH-1:0]  imem_rdata,
    output logic                    decode_valid,
    input  logic                    decode_ready,
    output logic [INSTR_WIDTH-1:0]  instr,
    output logic [PC_WIDTH-1:0]     instr_pc,
    output logic [IMM16_WIDTH-1:0]  imm_a,
    output logic [IMM21_WIDTH-1:0]  imm_b,
    output logic [IMM16_WIDTH-1:0]  imm_c,
    output logic [EXT_WIDTH-1:0]    ext_sel,
    input  logic                    redirect_valid,
    input  logic [PC_WIDTH-1:0]     redirect_pc
);

    localparam logic [PC_WIDTH-1:0] PC_INC = PC_WIDTH'(PC_STEP);

    fetchState_t          state;
    logic [PC_WIDTH-1:0]  pc;
    instrFields_t         fields;

    // imem_addr only moves when a new request opens, so it stays frozen
    // while a request (including one being discarded) is outstanding.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= REQ;
            pc           <= RESET_PC;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_PC;
            decode_valid <= 1'b0;
            instr        <= '0;
            instr_pc     <= '0;
        end else begin
            unique case (state)
                REQ: begin
                    if (!imem_req) begin
                        // First cycle out of reset: open the request
                        imem_req <= 1'b1;
                        if (redirect_valid) begin
                            pc        <= redirect_pc;
                            imem_addr <= redirect_pc;
                        end else begin
                            imem_addr <= pc;
                        end
                    end else if (redirect_valid) begin
                        pc <= redirect_pc;
                        if (imem_ack) begin
                            imem_addr <= redirect_pc;
                        end else begin
                            state <= DISCARD;
                        end
                    end else if (imem_ack) begin
                        instr        <= imem_rdata;
                        instr_pc     <= pc;
                        pc           <= pc + PC_INC;
                        imem_req     <= 1'b0;
                        decode_valid <= 1'b1;
                        state        <= VALID;
                    end
                end

                DISCARD: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end
                    if (imem_ack) begin
                        state     <= REQ;
                        imem_addr <= redirect_valid ? redirect_pc : pc;
                    end
                end

                VALID: begin
                    // A redirect squashes the held word even if decode is ready
                    if (redirect_valid || decode_ready) begin
                        decode_valid <= 1'b0;
                        imem_req     <= 1'b1;
                        state        <= REQ;
                        imem_addr    <= redirect_valid ? redirect_pc : pc;
                        if (redirect_valid) begin
                            pc <= redirect_pc;
                        end
                    end
                end

                default: begin
                    state <= REQ;
                end
            endcase
        end
    end

    instruction_field_split fieldSplit (
        .instr  (instr),
        .fields (fields)
    );

    assign imm_a   = fields.immA;
    assign imm_b   = fields.immB;
    assign imm_c   = fields.immC;
    assign ext_sel = fields.extSel;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: memory responder, program-order scoreboard
// and directed plus randomized fetch/redirect/reset scenarios.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          MAX_WAIT = 200;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        decode_valid;
    logic        decode_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [15:0] imm_a;
    logic [20:0] imm_b;
    logic [15:0] imm_c;
    logic [1:0]  ext_sel;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    int errors = 0;
    int checks = 0;
    int presented = 0;

    logic [31:0] mem [256];
    logic [31:0] expQ [$];

    int     memDelay = 0;
    bit     randDelay = 1'b0;
    int     curDelay = 0;
    int     waitCnt = 0;
    int     phaseId = 0;
    int     expectedGap = 0;
    longint cycle = 0;

    always #5 clock = ~clock;

    instruction_fetch_unit #(
        .PC_WIDTH (32),
        .RESET_PC (RESET_PC),
        .PC_STEP  (1)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .decode_valid   (decode_valid),
        .decode_ready   (decode_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .imm_a          (imm_a),
        .imm_b          (imm_b),
        .imm_c          (imm_c),
        .ext_sel        (ext_sel),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not seen within %0d cycles at time %0t", name, MAX_WAIT, $time);
    endtask

    function automatic logic [1:0] refExtSel(input logic [31:0] w);
        case (w[31:30])
            2'b01:   return 2'b00;
            2'b10:   return 2'b01;
            2'b11:   return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    always @(posedge clock) cycle <= cycle + 1;

    // Instruction memory: acks after curDelay waiting cycles, garbage data otherwise
    always @(posedge clock) begin
        #1;
        if (reset) begin
            imem_ack = 1'b0;
            waitCnt  = 0;
        end else if (imem_req) begin
            if (waitCnt >= curDelay) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr[7:0]];
                waitCnt    = 0;
                curDelay   = randDelay ? int'($urandom_range(0, 3)) : memDelay;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                waitCnt++;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            waitCnt    = 0;
            curDelay   = randDelay ? int'($urandom_range(0, 3)) : memDelay;
        end
    end

    // Program-order model: the next word decode sees is the one after the last
    // presented, unless reset or a redirect restarts the stream.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            expQ.delete();
            expQ.push_back(RESET_PC);
        end else if (redirect_valid) begin
            expQ.delete();
            expQ.push_back(redirect_pc);
        end
    end

    bit          prevValid = 1'b0;
    bit          prevReq = 1'b0;
    bit          prevAck = 1'b0;
    bit          prevReady = 1'b0;
    bit          prevRedirect = 1'b0;
    logic [31:0] prevAddr = 32'h0;
    logic [31:0] prevInstr = 32'h0;
    longint      lastPresentCycle = 0;
    int          lastPresentPhase = -1;

    always @(negedge clock) begin
        logic [31:0] expPc;
        logic [31:0] w;
        if (reset) begin
            prevValid        = 1'b0;
            prevReq          = 1'b0;
            prevAck          = 1'b0;
            lastPresentPhase = -1;
        end else begin
            if (prevReq && !prevAck) begin
                check("req_held", 64'(imem_req), 64'(1));
                check("addr_stable", 64'(imem_addr), 64'(prevAddr));
            end
            if (prevValid && !prevReady && !prevRedirect) begin
                check("valid_held", 64'(decode_valid), 64'(1));
                check("instr_held", 64'(instr), 64'(prevInstr));
            end
            if (decode_valid && !prevValid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got pc 0x%0h, expected no instruction", instr_pc);
                end else begin
                    expPc = expQ.pop_front();
                    w     = mem[expPc[7:0]];
                    check("instr_pc", 64'(instr_pc), 64'(expPc));
                    check("instr", 64'(instr), 64'(w));
                    check("imm_a", 64'(imm_a), 64'(w[15:0]));
                    check("imm_b", 64'(imm_b), 64'(w[20:0]));
                    check("imm_c", 64'(imm_c), 64'({w[25:21], w[10:0]}));
                    check("ext_sel", 64'(ext_sel), 64'(refExtSel(w)));
                    expQ.push_back(expPc + 32'd1);
                    if (expectedGap != 0 && lastPresentPhase == phaseId)
                        check("fetch_gap", 64'(cycle - lastPresentCycle), 64'(expectedGap));
                    lastPresentCycle = cycle;
                    lastPresentPhase = phaseId;
                    presented++;
                end
            end
            prevValid    = decode_valid;
            prevReq      = imem_req;
            prevAck      = imem_ack;
            prevReady    = decode_ready;
            prevRedirect = redirect_valid;
            prevAddr     = imem_addr;
            prevInstr    = instr;
        end
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    int          n;
    logic [31:0] oldAddr;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int i = 0; i < 8; i++) mem[i] = 32'h4000_1234;
        mem[8] = 32'h8010_0005;

        // Reset values
        repeat (2) @(posedge clock);
        #1;
        check("rst_imem_req", 64'(imem_req), 64'(0));
        check("rst_decode_valid", 64'(decode_valid), 64'(0));
        check("rst_instr", 64'(instr), 64'(0));
        check("rst_instr_pc", 64'(instr_pc), 64'(0));
        check("rst_imm_a", 64'(imm_a), 64'(0));
        check("rst_imm_b", 64'(imm_b), 64'(0));
        check("rst_imm_c", 64'(imm_c), 64'(0));
        check("rst_ext_sel", 64'(ext_sel), 64'(2'b11));

        // Back-to-back fetch with immediate acks
        phaseId      = 1;
        expectedGap  = 2;
        decode_ready = 1'b1;
        reset        = 1'b0;
        @(posedge clock);
        #1;
        check("req_after_reset", 64'(imem_req), 64'(1));
        check("addr_after_reset", 64'(imem_addr), 64'(RESET_PC));
        n = 0;
        while (!(decode_valid && instr_pc == 32'd7) && n < MAX_WAIT) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= MAX_WAIT) timeoutFail("wait_pc7");

        // Decode stalls on the J-type word
        @(posedge clock);
        #1;
        decode_ready = 1'b0;
        phaseId      = 2;
        expectedGap  = 0;
        memDelay     = 3;
        n = 0;
        while (!decode_valid && n < MAX_WAIT) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= MAX_WAIT) timeoutFail("wait_hold_valid");
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 64'(decode_valid), 64'(1));
            check("hold_instr", 64'(instr), 64'(32'h8010_0005));
            check("hold_imm_b", 64'(imm_b), 64'(21'h10_0005));
            check("hold_ext_sel", 64'(ext_sel), 64'(2'b01));
            check("hold_no_req", 64'(imem_req), 64'(0));
            @(posedge clock);
            #1;
        end

        // Slow memory: three wait cycles per fetch
        decode_ready = 1'b1;
        phaseId      = 3;
        expectedGap  = 5;
        repeat (30) begin
            @(posedge clock);
            #1;
        end

        // Redirect while a request is outstanding
        phaseId     = 4;
        expectedGap = 0;
        n = 0;
        while (!(imem_req && !decode_valid) && n < MAX_WAIT) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= MAX_WAIT) timeoutFail("wait_pending_req");
        oldAddr        = imem_addr;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        @(posedge clock);
        #1;
        redirect_valid = 1'b0;
        n = 0;
        while (!(imem_req && imem_addr != oldAddr) && n < MAX_WAIT) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= MAX_WAIT) timeoutFail("wait_redirect_req");
        check("redirect_addr", 64'(imem_addr), 64'(32'h40));
        n = 0;
        while (!decode_valid && n < MAX_WAIT) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= MAX_WAIT) timeoutFail("wait_redirect_valid");
        check("redirect_first_pc", 64'(instr_pc), 64'(32'h40));

        // Redirect coincident with decode_ready
        phaseId  = 5;
        memDelay = 0;
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        n = 0;
        while (!decode_valid && n < MAX_WAIT) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= MAX_WAIT) timeoutFail("wait_valid_for_squash");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        @(posedge clock);
        #1;
        redirect_valid = 1'b0;
        check("squash_valid", 64'(decode_valid), 64'(0));
        check("squash_req", 64'(imem_req), 64'(1));
        check("squash_addr", 64'(imem_addr), 64'(32'h80));
        n = 0;
        while (!decode_valid && n < MAX_WAIT) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= MAX_WAIT) timeoutFail("wait_squash_refetch");
        check("squash_first_pc", 64'(instr_pc), 64'(32'h80));

        // Randomized ready, memory latency and redirects
        phaseId   = 6;
        randDelay = 1'b1;
        for (int i = 0; i < 800; i++) begin
            decode_ready   = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = 32'($urandom_range(0, 255));
            @(posedge clock);
            #1;
        end
        redirect_valid = 1'b0;
        decode_ready   = 1'b1;
        randDelay      = 1'b0;
        memDelay       = 0;
        repeat (10) begin
            @(posedge clock);
            #1;
        end

        // Reset in the middle of a request
        phaseId = 7;
        n = 0;
        while (!imem_req && n < MAX_WAIT) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= MAX_WAIT) timeoutFail("wait_req_for_reset");
        #2;
        reset = 1'b1;
        #1;
        check("midrst_req", 64'(imem_req), 64'(0));
        check("midrst_valid", 64'(decode_valid), 64'(0));
        check("midrst_instr", 64'(instr), 64'(0));
        check("midrst_ext_sel", 64'(ext_sel), 64'(2'b11));
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("restart_req", 64'(imem_req), 64'(1));
        check("restart_addr", 64'(imem_addr), 64'(RESET_PC));
        check("restart_ext_sel", 64'(ext_sel), 64'(2'b11));
        check("restart_valid", 64'(decode_valid), 64'(0));
        n = 0;
        while (!decode_valid && n < MAX_WAIT) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= MAX_WAIT) timeoutFail("wait_restart_valid");
        check("restart_first_pc", 64'(instr_pc), 64'(RESET_PC));
        repeat (10) begin
            @(posedge clock);
            #1;
        end

        check("enough_instructions", 64'(presented >= 30), 64'(1));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of the Galetron core. It holds the program counter and runs a request/acknowledge handshake with instruction memory. It latches each returned word into an instruction register and presents it to decode through a valid/ready handshake. It also splits out the three immediate fields and the 2-bit extender selection that feed the immediate extender directly downstream.

## Interface
Parameters:
- PC_WIDTH, 32: program-counter and memory-address width.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- PC_STEP, 1: increment per instruction (word addressing).

Ports:
- clock, input, 1: single clock; all state changes on its rising edge.
- reset, input, 1: asynchronous, active-high; clears all state immediately.
- imem_req, output, 1: fetch request; held until acknowledged.
- imem_addr, output, PC_WIDTH: fetch address; stable while imem_req=1.
- imem_ack, input, 1: memory returns imem_rdata this cycle.
- imem_rdata, input, 32: instruction word.
- decode_valid, output, 1: instruction register holds a valid instruction.
- decode_ready, input, 1: decode accepts this cycle.
- instr, output, 32: instruction register.
- instr_pc, output, PC_WIDTH: address the instruction was fetched from.
- imm_a, output, 16: instr[15:0].
- imm_b, output, 21: instr[20:0].
- imm_c, output, 16: {instr[25:21], instr[10:0]}.
- ext_sel, output, 2: extender selection.
- redirect_valid, input, 1: branch/jump taken; flush the wrong path.
- redirect_pc, input, PC_WIDTH: new fetch address.

## Operation
- FSM states: REQ, DISCARD, VALID.
- Reset values:
  - State is REQ; pc is RESET_PC.
  - imem_req is 0 while reset is asserted.
  - instr, instr_pc and decode_valid are 0.
  - imm_a, imm_b and imm_c are 0; ext_sel is 2'b11.
- REQ state:
  - Outputs: imem_req=1, imem_addr=pc.
  - On imem_ack: instr<=imem_rdata, instr_pc<=pc, pc<=pc+PC_STEP, next state VALID.
- VALID state:
  - Outputs: decode_valid=1, imem_req=0.
  - On decode_ready: next state REQ.
  - Without decode_ready: hold instr and all outputs unchanged.
- Redirect handling (redirect_valid=1 takes priority over everything else):
  - In REQ with imem_ack: discard the data, pc<=redirect_pc, stay in REQ.
  - In REQ without imem_ack: pc<=redirect_pc, go to DISCARD. The outstanding request stays asserted with the old address until acknowledged.
  - In DISCARD: pc<=redirect_pc (the latest redirect wins).
  - In VALID: pc<=redirect_pc, decode_valid<=0, go to REQ. A valid&ready in the same cycle is not a transfer; decode squashes on the same redirect.
- DISCARD state:
  - Outputs: imem_req=1, imem_addr=the old address.
  - On imem_ack: drop the data, go to REQ. Redirect in the same cycle also updates pc.
- ext_sel is decoded from opcode class instr[31:30]:
  - 01 (I-type) -> 2'b00
  - 10 (J-type) -> 2'b01
  - 11 (store) -> 2'b10
  - 00 (R-type) -> 2'b11
- imm_a, imm_b, imm_c and ext_sel are combinational from instr. They are therefore stable whenever instr is held.
- pc wraps modulo 2^PC_WIDTH; no overflow flag.

## Timing
- Reset deassertion:
  - imem_req rises in the first cycle after reset deasserts.
  - imem_addr=RESET_PC.
- Fetch latency:
  - decode_valid rises on the edge after the imem_ack cycle.
  - Best case is 1 cycle from request to valid.
- Throughput:
  - Maximum is 1 instruction per 2 cycles (REQ then VALID).
  - Any cycle without imem_ack extends REQ by one cycle.
- Handshake rules:
  - imem_req never drops before imem_ack.
  - imem_addr never changes while imem_req=1.
- Redirect:
  - The first fetch from redirect_pc is requested on the cycle after the redirect, unless the FSM is in DISCARD.
  - In DISCARD, that fetch waits for the pending ack.
- Reset mid-operation: imem_req and decode_valid fall asynchronously. Memory must tolerate an abandoned request.

## Structure
- Shared package galetron_pkg holds:
  - opcode-class constants;
  - ext_sel encodings EXT_IMM16A=2'b00, EXT_IMM21=2'b01, EXT_IMM16C=2'b10, EXT_NONE=2'b11;
  - the fetch FSM state enum.
- Sub-module instruction_field_split:
  - Combinational; maps instr to imm_a, imm_b, imm_c and ext_sel.
  - Reused by the decode stage.

## Test plan
- Reset, then memory acks every request immediately with instr=32'h4000_1234 -> imem_addr 0,1,2,…; decode_valid every 2nd cycle; imm_a=16'h1234, ext_sel=2'b00.
- Hold decode_ready=0 for 5 cycles in VALID with instr=32'h8010_0005 -> instr, imm_b=21'h10_0005 and ext_sel=2'b01 stable; no new imem_req.
- Memory delays ack 3 cycles -> imem_req and imem_addr held constant; decode_valid 1 cycle after ack.
- Redirect to 32'h40 while REQ is pending with no ack -> DISCARD; the old ack is dropped; the next imem_addr is 32'h40; no decode_valid for the dropped word.
- Redirect to 32'h80 coincident with decode_ready in VALID -> decode_valid=0 next cycle; the next request is at 32'h80.
- Assert reset mid-REQ -> imem_req=0 in the same cycle; after release, the fetch restarts at RESET_PC and ext_sel=2'b11 until the first instruction.
